// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter sequencer.
package pc_seq_pkg;

  localparam int unsigned PC_INCR = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SEL_SEQ    = 2'd0,
    SEL_BRANCH = 2'd1,
    SEL_JUMP   = 2'd2
  } pc_sel_e;

endpackage

// File: rtl/next_pc_select.sv
// Priority next-PC mux: jump > taken branch > sequential.
// With `define MISALIGN_TRAP_EN it also flags a non-word-aligned non-sequential target.
module next_pc_select
  import pc_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] pc_plus4,
  input  logic             branch,
  input  logic             alu_zero,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  output logic [WIDTH-1:0] next_pc_c,
  output pc_sel_e          sel_c,
  output logic             taken_c
`ifdef MISALIGN_TRAP_EN
  ,
  output logic             misalign_c
`endif
);

  always_comb begin
    sel_c     = SEL_SEQ;
    next_pc_c = pc_plus4;
    if (jump) begin
      sel_c     = SEL_JUMP;
      next_pc_c = jump_target;
    end else if (branch && alu_zero) begin
      sel_c     = SEL_BRANCH;
      next_pc_c = branch_target;
    end
  end

  assign taken_c = (sel_c != SEL_SEQ);

`ifdef MISALIGN_TRAP_EN
  assign misalign_c = taken_c && (next_pc_c[1:0] != 2'b00);
`endif

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: IDLE/FETCH/EXEC control around a handshaked instruction memory.
// Optional misaligned-target trap enabled with `define MISALIGN_TRAP_EN.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(32'h0000_0000)
`ifdef MISALIGN_TRAP_EN
  ,
  parameter logic [WIDTH-1:0] TRAP_PC  = WIDTH'(32'h0000_0080)
`endif
) (
  input  logic             clock,
  input  logic             reset,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic             branch,
  input  logic             alu_zero,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             stall,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             instr_valid,
  output logic             redirect,
  output logic [31:0]      instret,
  output logic             trap
);

  localparam int unsigned CNT_W = 32;

  state_e           state_q, state_d;
  logic             retire;
  logic [WIDTH-1:0] pc_q, pc_load, sel_pc;
  logic [CNT_W-1:0] instret_q;
  pc_sel_e          sel;
  logic             taken;

  assign pc          = pc_q;
  assign pc_plus4    = pc_q + WIDTH'(PC_INCR);
  assign imem_addr   = pc_q;
  assign imem_req    = (state_q == FETCH);
  assign instr_valid = (state_q == EXEC);
  assign instret     = instret_q;

`ifdef MISALIGN_TRAP_EN
  logic misalign;
`endif

  next_pc_select #(.WIDTH(WIDTH)) u_next_pc (
    .pc_plus4      (pc_plus4),
    .branch        (branch),
    .alu_zero      (alu_zero),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .next_pc_c     (sel_pc),
    .sel_c         (sel),
    .taken_c       (taken)
`ifdef MISALIGN_TRAP_EN
    ,
    .misalign_c    (misalign)
`endif
  );

  // Select code and taken flag are two views of the same decision
  always_comb begin
    assert (taken == (sel != SEL_SEQ));
  end

`ifdef MISALIGN_TRAP_EN
  assign pc_load = misalign ? TRAP_PC : sel_pc;
  assign trap    = retire & misalign;
`else
  assign pc_load = sel_pc;
  assign trap    = 1'b0;
`endif

  assign redirect = retire & taken;

  // Next-state logic; retire marks the unstalled EXEC cycle that commits
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    unique case (state_q)
      IDLE:  state_d = FETCH;
      FETCH: if (imem_ack) state_d = EXEC;
      EXEC: begin
        if (!stall) begin
          state_d = FETCH;
          retire  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q      <= RESET_PC;
      instret_q <= '0;
    end else if (retire) begin
      pc_q      <= pc_load;
      instret_q <= instret_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus a randomized run against a per-instruction model.
module tb_pc_sequencer;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] TRAP_PC  = 32'h0000_0080;

  logic        clock;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic        branch;
  logic        alu_zero;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        stall;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        instr_valid;
  logic        redirect;
  logic [31:0] instret;
  logic        trap;

  int vectors = 0;
  int miscompares = 0;

  // Architectural model: PC and retired count as seen between instructions
  logic [31:0] m_pc;
  logic [31:0] m_instret;

  pc_sequencer dut (
    .clock         (clock),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .branch        (branch),
    .alu_zero      (alu_zero),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .stall         (stall),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .instr_valid   (instr_valid),
    .redirect      (redirect),
    .instret       (instret),
    .trap          (trap)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check_bit({tag, "_req"}, imem_req, 1'b0);
    check_bit({tag, "_valid"}, instr_valid, 1'b0);
    check_bit({tag, "_redirect"}, redirect, 1'b0);
    check_bit({tag, "_trap"}, trap, 1'b0);
    check32({tag, "_pc"}, pc, m_pc);
    check32({tag, "_instret"}, instret, m_instret);
  endtask

  // FETCH: ack arrives after 'delay' waiting cycles; control inputs are noise here
  task automatic fetch_instr(input int delay);
    for (int k = 0; k <= delay; k++) begin
      @(negedge clock);
      imem_ack = (k == delay);
      stall    = 1'b0;
      branch   = 1'($urandom);
      alu_zero = 1'($urandom);
      jump     = 1'($urandom);
      #1;
      check_bit("fetch_req", imem_req, 1'b1);
      check_bit("fetch_valid", instr_valid, 1'b0);
      check_bit("fetch_redirect", redirect, 1'b0);
      check32("fetch_addr", imem_addr, m_pc);
      check32("fetch_pc4", pc_plus4, m_pc + 32'd4);
      check32("fetch_instret", instret, m_instret);
    end
  endtask

  // EXEC: 'stalls' held cycles with random controls, then the real decision
  task automatic exec_instr(input int stalls, input logic br, input logic z,
                            input logic [31:0] bt, input logic j, input logic [31:0] jt);
    logic        nonseq;
    logic [31:0] tgt;
    logic [31:0] npc;
    logic        etrap;
    nonseq = j || (br && z);
    tgt    = j ? jt : bt;
    npc    = nonseq ? tgt : m_pc + 32'd4;
    etrap  = 1'b0;
`ifdef MISALIGN_TRAP_EN
    if (nonseq && (tgt[1:0] != 2'b00)) begin
      etrap = 1'b1;
      npc   = TRAP_PC;
    end
`endif
    for (int k = 0; k <= stalls; k++) begin
      @(negedge clock);
      imem_ack = 1'($urandom);
      stall    = (k < stalls);
      if (k < stalls) begin
        branch        = 1'($urandom);
        alu_zero      = 1'($urandom);
        jump          = 1'($urandom);
        branch_target = $urandom;
        jump_target   = $urandom;
      end else begin
        branch        = br;
        alu_zero      = z;
        jump          = j;
        branch_target = bt;
        jump_target   = jt;
      end
      #1;
      check_bit("exec_valid", instr_valid, 1'b1);
      check_bit("exec_req", imem_req, 1'b0);
      check32("exec_pc", pc, m_pc);
      check32("exec_instret", instret, m_instret);
      check_bit("exec_redirect", redirect, (k < stalls) ? 1'b0 : nonseq);
      check_bit("exec_trap", trap, (k < stalls) ? 1'b0 : etrap);
    end
    m_pc      = npc;
    m_instret = m_instret + 32'd1;
  endtask

  task automatic instr(input int delay, input int stalls, input logic br, input logic z,
                       input logic [31:0] bt, input logic j, input logic [31:0] jt);
    fetch_instr(delay);
    exec_instr(stalls, br, z, bt, j, jt);
  endtask

  initial begin
    reset         = 1'b0;
    imem_ack      = 1'b0;
    branch        = 1'b0;
    alu_zero      = 1'b0;
    branch_target = '0;
    jump          = 1'b0;
    jump_target   = '0;
    stall         = 1'b0;
    m_pc          = RESET_PC;
    m_instret     = 32'd0;

    repeat (3) @(negedge clock);
    #1;
    check_quiet("reset");

    // Release; first cycle is the IDLE bubble even with ack asserted
    @(negedge clock);
    reset    = 1'b1;
    imem_ack = 1'b1;
    #1;
    check_quiet("idle");

    // Straight-line code: 0x0, 0x4, 0x8, then 0xC to reach 0x10
    for (int i = 0; i < 4; i++) instr(0, 0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check32("instret_after_4", m_instret, 32'd4);

    instr(0, 0, 1'b1, 1'b1, 32'h40, 1'b0, 32'h0);       // taken branch 0x10 -> 0x40
    instr(0, 0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h10);       // jump back to 0x10
    instr(0, 0, 1'b1, 1'b0, 32'h40, 1'b0, 32'h0);       // not taken -> 0x14
    instr(0, 0, 1'b1, 1'b1, 32'h40, 1'b1, 32'h100);     // jump beats branch -> 0x100
    instr(0, 0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h20);       // to 0x20
    instr(0, 3, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);        // 3-cycle stall at 0x20 -> 0x24
    instr(4, 0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);        // ack after 4 waits at 0x24
    instr(0, 0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
    instr(0, 0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);        // wraps to 0x0
    instr(0, 0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h102);      // misaligned jump
    instr(1, 1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0200);

    // Randomized mix of delays, stalls, branches and jumps
    for (int i = 0; i < 40; i++) begin
      logic [31:0] bt;
      logic [31:0] jt;
      bt = $urandom;
      jt = $urandom;
      if ($urandom_range(3) != 0) bt[1:0] = 2'b00;
      if ($urandom_range(3) != 0) jt[1:0] = 2'b00;
      instr($urandom_range(3), $urandom_range(2), 1'($urandom), 1'($urandom), bt,
            ($urandom_range(3) == 0), jt);
    end

    // Asynchronous reset in the middle of a FETCH at 0x30
    instr(0, 0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h30);
    @(negedge clock);
    imem_ack = 1'b0;
    #1;
    check_bit("midfetch_req", imem_req, 1'b1);
    check32("midfetch_addr", imem_addr, 32'h30);
    #2;
    reset = 1'b0;
    #1;
    m_pc      = RESET_PC;
    m_instret = 32'd0;
    check_quiet("async_reset");

    @(negedge clock);
    reset = 1'b1;
    #1;
    check_quiet("idle2");
    instr(0, 0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    instr(2, 0, 1'b1, 1'b1, 32'h80, 1'b0, 32'h0);
    fetch_instr(0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
